// File: rtl/shift_add_multiplier.sv
// Sequential unsigned N x N -> 2N shift-and-add multiplier, one adder pass per multiplier bit.
// Define MUL_SIGNED_EN to add a signed_op port and a one-cycle NEG state for two's complement.
module shift_add_multiplier #(
  parameter int unsigned N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
`ifdef MUL_SIGNED_EN
  input  logic           signed_op,
`endif
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
`ifdef MUL_SIGNED_EN
    , StNeg
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [N:0]       acc_q, acc_d;
  logic [N-1:0]     mq_q, mq_d;
  logic [N-1:0]     mcand_q, mcand_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*N-1:0]   product_q, product_d;
`ifdef MUL_SIGNED_EN
  logic             sgn_q, sgn_d;
  logic             signed_q, signed_d;
`endif

  logic [N-1:0]     addend;
  logic [N:0]       sum;
  logic [N:0]       acc_shift;
  logic [N-1:0]     mq_shift;
  logic             accept;

  // Adder stage: acc[N] is always zero between passes, so the full-width add equals A + B.
  always_comb begin
    addend    = mq_q[0] ? mcand_q : '0;
    sum       = acc_q + {1'b0, addend};
    acc_shift = {1'b0, sum[N:1]};
    mq_shift  = {sum[0], mq_q[N-1:1]};
  end

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    mcand_d   = mcand_q;
    count_d   = count_q;
    product_d = product_q;
`ifdef MUL_SIGNED_EN
    sgn_d     = sgn_q;
    signed_d  = signed_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StRun;
          acc_d   = '0;
          count_d = '0;
`ifdef MUL_SIGNED_EN
          signed_d = signed_op;
          if (signed_op) begin
            // Magnitude of -2^(N-1) is 2^(N-1), which still fits in N unsigned bits.
            mcand_d = a[N-1] ? (~a + 1'b1) : a;
            mq_d    = b[N-1] ? (~b + 1'b1) : b;
            sgn_d   = a[N-1] ^ b[N-1];
          end else begin
            mcand_d = a;
            mq_d    = b;
            sgn_d   = 1'b0;
          end
`else
          mcand_d = a;
          mq_d    = b;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        acc_d   = acc_shift;
        mq_d    = mq_shift;
        count_d = count_q + 1'b1;
        if (count_q == CW'(N - 1)) begin
          product_d = {acc_shift[N-1:0], mq_shift};
`ifdef MUL_SIGNED_EN
          state_d   = signed_q ? StNeg : StDone;
`else
          state_d   = StDone;
`endif
        end
      end
`ifdef MUL_SIGNED_EN
      StNeg: begin
        product_d = sgn_q ? (~product_q + 1'b1) : product_q;
        state_d   = StDone;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      mq_q      <= '0;
      mcand_q   <= '0;
      count_q   <= '0;
      product_q <= '0;
`ifdef MUL_SIGNED_EN
      sgn_q     <= 1'b0;
      signed_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      mcand_q   <= mcand_d;
      count_q   <= count_d;
      product_q <= product_d;
`ifdef MUL_SIGNED_EN
      sgn_q     <= sgn_d;
      signed_q  <= signed_d;
`endif
    end
  end

`ifdef MUL_SIGNED_EN
  assign busy = (state_q == StRun) || (state_q == StNeg);
`else
  assign busy = (state_q == StRun);
`endif
  assign done    = (state_q == StDone);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier at N=8 with a plain-arithmetic reference model.
module tb_shift_add_multiplier;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_op;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef MUL_SIGNED_EN
    .signed_op (signed_op),
`endif
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  // Advance one edge; outputs are then observed 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib);
    a = ia;
    b = ib;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts edges until done is seen, giving up after limit edges.
  task automatic wait_done(input int limit, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < limit) begin
      tick();
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y);
    longint unsigned p;
    p = longint'(x) * longint'(y);
    return p[2*N-1:0];
  endfunction

  function automatic logic [2*N-1:0] ref_smul(input logic [N-1:0] x, input logic [N-1:0] y);
    longint sx, sy, p;
    sx = x[N-1] ? longint'(x) - (longint'(1) << N) : longint'(x);
    sy = y[N-1] ? longint'(y) - (longint'(1) << N) : longint'(y);
    p  = sx * sy;
    return p[2*N-1:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b product=%h, required 0 0 0000", busy, done, product);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_max();
    int busy_cnt = 0;
    issue(8'hFF, 8'hFF);
    for (int i = 0; i < N; i++) begin
      if (busy === 1'b1 && done === 1'b0) busy_cnt++;
      tick();
    end
    checks++;
    if (busy_cnt != N) begin
      errors++;
      $display("FAIL max_busy: busy cycles=%0d, required %0d", busy_cnt, N);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || product !== 16'hFE01) begin
      errors++;
      $display("FAIL max_done: done=%b busy=%b product=%h, required 1 0 fe01", done, busy, product);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || product !== 16'hFE01) begin
        errors++;
        $display("FAIL max_hold: done=%b product=%h, required 0 fe01", done, product);
      end
    end
  endtask

  task automatic test_ignored_start();
    int cyc;
    bit seen;
    issue(8'd13, 8'd11);
    tick();
    tick();
    a = 8'd2;
    b = 8'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(4 * N, cyc, seen);
    checks++;
    if (!seen || cyc != N - 3 || product !== 16'h008F) begin
      errors++;
      $display("FAIL ignored_start: seen=%b cyc=%0d product=%h, required 1 %0d 008f",
               seen, cyc, product, N - 3);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    issue(8'd7, 8'd9);
    a = 8'd0;
    b = 8'd200;
    start = 1'b1;
    wait_done(4 * N, cyc, seen);
    checks++;
    if (!seen || cyc != N || product !== 16'd63) begin
      errors++;
      $display("FAIL b2b_first: seen=%b cyc=%0d product=%h, required 1 %0d 003f",
               seen, cyc, product, N);
    end
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || product !== 16'd63) begin
      errors++;
      $display("FAIL b2b_gap: busy=%b product=%h, required 1 003f", busy, product);
    end
    wait_done(4 * N, cyc, seen);
    checks++;
    if (!seen || cyc != N || product !== 16'd0) begin
      errors++;
      $display("FAIL b2b_second: seen=%b cyc=%0d product=%h, required 1 %0d 0000",
               seen, cyc, product, N);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    int cyc;
    bit seen;
    int dones = 0;
    issue(8'd200, 8'd100);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== '0) begin
      errors++;
      $display("FAIL midrun_reset: busy=%b done=%b product=%h, required 0 0 0000",
               busy, done, product);
    end
    for (int i = 0; i < N + 2; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midrun_nodone: done pulses=%0d, required 0", dones);
    end
    issue(8'd5, 8'd6);
    wait_done(4 * N, cyc, seen);
    checks++;
    if (!seen || cyc != N || product !== 16'd30) begin
      errors++;
      $display("FAIL after_reset: seen=%b cyc=%0d product=%h, required 1 %0d 001e",
               seen, cyc, product, N);
    end
    tick();
  endtask

  task automatic test_random();
    int cyc;
    bit seen;
    logic [N-1:0] ra, rb;
    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if (i == 0) ra = '0;
      if (i == 1) rb = '0;
      signed_op = 1'b0;
      issue(ra, rb);
      wait_done(4 * N, cyc, seen);
      checks++;
      if (!seen || cyc != N || product !== ref_mul(ra, rb)) begin
        errors++;
        $display("FAIL random %0d*%0d: seen=%b cyc=%0d product=%h, required 1 %0d %h",
                 ra, rb, seen, cyc, product, N, ref_mul(ra, rb));
      end
      if ($urandom_range(1, 0) == 1) tick();
    end
  endtask

`ifdef MUL_SIGNED_EN
  task automatic test_signed();
    int cyc;
    bit seen;
    logic [N-1:0] va [0:1];
    logic [N-1:0] vb [0:1];
    logic [2*N-1:0] exp_p [0:1];
    logic [N-1:0] ra, rb;
    va[0] = 8'h80; vb[0] = 8'hFF; exp_p[0] = 16'h0080;
    va[1] = 8'hFD; vb[1] = 8'h05; exp_p[1] = 16'hFFF1;
    for (int i = 0; i < 2; i++) begin
      signed_op = 1'b1;
      issue(va[i], vb[i]);
      wait_done(4 * N, cyc, seen);
      checks++;
      if (!seen || cyc != N + 1 || product !== exp_p[i]) begin
        errors++;
        $display("FAIL signed_fixed %0d: seen=%b cyc=%0d product=%h, required 1 %0d %h",
                 i, seen, cyc, product, N + 1, exp_p[i]);
      end
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      signed_op = 1'b1;
      issue(ra, rb);
      wait_done(4 * N, cyc, seen);
      checks++;
      if (!seen || cyc != N + 1 || product !== ref_smul(ra, rb)) begin
        errors++;
        $display("FAIL signed_random %h*%h: seen=%b cyc=%0d product=%h, required 1 %0d %h",
                 ra, rb, seen, cyc, product, N + 1, ref_smul(ra, rb));
      end
      tick();
    end
    signed_op = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b0;
    start = 1'b0;
    signed_op = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_max();
    test_ignored_start();
    test_back_to_back();
    test_reset_midrun();
    test_random();
`ifdef MUL_SIGNED_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned N x N -> 2N shift-and-add multiplier.
- Sits directly around the team's N-bit ripple-carry adder stage. Each cycle it drives that adder's A/B/Cin from its accumulator and multiplicand, then consumes the adder's sum and carry-out.
- One adder pass per multiplier bit, so the datapath stays a single N-bit adder in area.
- Start/busy/done handshake for use by the surrounding PDA datapath control.

Parameters:
- N, 32, operand width in bits; must be >= 2. The product is 2N bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a multiply; sampled only when busy=0.
- a  in  N  multiplicand; captured on an accepted start.
- b  in  N  multiplier; captured on an accepted start.
- busy  out  1  high while a multiply is in progress.
- done  out  1  one-cycle pulse when product becomes valid.
- product  out  2N  result; held stable until the next accepted start.

Behaviour:
- Reset: on any clock edge with rst=1, the block returns to IDLE regardless of state.
  - busy=0, done=0, product=0, internal acc/mq/count cleared.
  - A multiply in flight is abandoned; no done pulse is generated.
  - rst has priority over start.
- States:
  - IDLE: busy=0, done=0. If start=1 go to RUN.
  - RUN: busy=1, done=0. After the Nth iteration go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. If start=1 go to RUN (back-to-back accept), else go to IDLE.
- Accept: start is taken when state is IDLE or DONE. On that edge:
  - mcand<=a, mq<=b, acc<=0 (N+1 bits), count<=0.
  - start while busy=1 is ignored; operands are not re-captured.
- Iteration, one per RUN cycle:
  - Adder inputs: A=acc[N-1:0], B = mq[0] ? mcand : 0, Cin=0.
  - Shift right by one bit: {acc, mq} <= {Cout, Q, mq} >> 1.
  - count increments by 1.
- Completion:
  - On the edge where count==N-1 in RUN, the final shift is performed and product<={acc, mq} (post-shift) is registered.
  - The state goes to DONE on that same edge.
- Latency: start accepted at edge T -> done=1 in the cycle following edge T+N. That is N RUN cycles; busy is high for exactly N cycles.
- product:
  - Updates only on the completion edge.
  - Retains its value through IDLE and through the next multiply's RUN cycles.
- Width rules:
  - The product never overflows; (2^N-1)^2 fits in 2N bits.
  - Adder carry-out is carried into acc[N] and must not be dropped.
  - count is $clog2(N)+1 bits wide.
- Zero operands: still take the full N cycles; product=0.

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined:
  - Adds input port signed_op (1 bit), sampled on accept.
  - When signed_op=1, a and b are two's complement. Their magnitudes are loaded, and the result sign sgn = a[N-1]^b[N-1] is stored.
  - After RUN, an extra NEG state lasts one cycle with busy=1. If sgn=1, it negates the 2N-bit product (invert, +1); otherwise it passes the product through.
  - Signed latency is N+1 cycles. Unsigned (signed_op=0) latency stays N and skips NEG.
  - The most negative value (-2^(N-1)) is handled correctly: its magnitude fits in N unsigned bits.
- Undefined: no signed_op port, no NEG state; the block is unsigned only.

Test Plan:
- N=8, rst held 2 cycles then released -> busy=0, done=0, product=0x0000.
- N=8, start with a=0xFF, b=0xFF -> busy high for 8 cycles; done pulses in the cycle after edge T+8; product=0xFE01 and stays held for 5 idle cycles.
- N=8, start a=13, b=11; assert start again with a=2, b=3 during cycle 3 of RUN -> the second start is ignored; product=143 (0x008F).
- N=8, a=7, b=9, then start=1 held through the DONE cycle with a=0, b=200 -> first product=63; the second multiply starts with no idle gap; product=0 after 8 more cycles.
- N=8, a=200, b=100, rst=1 asserted at RUN cycle 4 -> next cycle busy=0, product=0, no done pulse. A subsequent 5*6 multiply gives 30.
- N=8, MUL_SIGNED_EN defined, signed_op=1, a=0x80 (-128), b=0xFF (-1) -> 9-cycle latency, product=0x0080 (+128). Then a=0xFD (-3), b=0x05 -> product=0xFFF1 (-15).
